// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory waits, EX redirects, load-use hazards and
// fetch stalls into per-stage hold/flush controls, with stall and flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  imem_busywait,
    input  logic                  dmem_busywait,
    input  logic                  branch_jump_signal,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  pc_stall,
    output logic                  if_id_busywait,
    output logic                  id_ex_busywait,
    output logic                  ex_mem_busywait,
    output logic                  mem_wb_busywait,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            ctrl_state,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
);

    typedef enum logic [1:0] {
        StRun      = 2'b00,
        StLoadUse  = 2'b01,
        StMemWait  = 2'b10,
        StRedirect = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic        load_use;
    logic        stall_ev;
    logic        flush_ev;

    // The consumer was already stalled (LOAD_USE) or squashed (REDIRECT), so do not re-detect.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
        if (state_q == StLoadUse || state_q == StRedirect) begin
            load_use = 1'b0;
        end
    end

    always_comb begin
        pc_stall        = 1'b0;
        if_id_busywait  = 1'b0;
        id_ex_busywait  = 1'b0;
        ex_mem_busywait = 1'b0;
        mem_wb_busywait = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        stall_ev        = 1'b0;
        flush_ev        = 1'b0;
        state_d         = StRun;

        // A branch under a data-memory wait stays in the held EX stage and is seen again later.
        if (dmem_busywait) begin
            pc_stall        = 1'b1;
            if_id_busywait  = 1'b1;
            id_ex_busywait  = 1'b1;
            ex_mem_busywait = 1'b1;
            mem_wb_busywait = 1'b1;
            stall_ev        = 1'b1;
            state_d         = StMemWait;
        end else if (branch_jump_signal) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_ev    = 1'b1;
            state_d     = StRedirect;
        end else if (load_use) begin
            pc_stall       = 1'b1;
            if_id_busywait = 1'b1;
            id_ex_flush    = 1'b1;
            stall_ev       = 1'b1;
            state_d        = StLoadUse;
        end else if (imem_busywait) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            stall_ev    = 1'b1;
        end

        if (!reset) begin
            pc_stall        = 1'b1;
            if_id_busywait  = 1'b0;
            id_ex_busywait  = 1'b0;
            ex_mem_busywait = 1'b0;
            mem_wb_busywait = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            stall_ev        = 1'b0;
            flush_ev        = 1'b0;
            state_d         = StRun;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_ev && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (flush_ev && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign ctrl_state  = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues hand-computed expectations
// per cycle, the monitor pops and compares them mid-cycle on the falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_busywait, dmem_busywait, branch_jump_signal;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_mem_read;
    logic        pc_stall, if_id_busywait, id_ex_busywait, ex_mem_busywait, mem_wb_busywait;
    logic        if_id_flush, id_ex_flush;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_count, flush_count;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;   // {pc_stall, if_id_bw, id_ex_bw, ex_mem_bw, mem_wb_bw, if_id_fl, id_ex_fl}
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5)) dut (
        .clk                (clk),
        .reset              (reset),
        .imem_busywait      (imem_busywait),
        .dmem_busywait      (dmem_busywait),
        .branch_jump_signal (branch_jump_signal),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_rs1_used        (id_rs1_used),
        .id_rs2_used        (id_rs2_used),
        .ex_rd              (ex_rd),
        .ex_mem_read        (ex_mem_read),
        .pc_stall           (pc_stall),
        .if_id_busywait     (if_id_busywait),
        .id_ex_busywait     (id_ex_busywait),
        .ex_mem_busywait    (ex_mem_busywait),
        .mem_wb_busywait    (mem_wb_busywait),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .ctrl_state         (ctrl_state),
        .stall_count        (stall_count),
        .flush_count        (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic dm, input logic im, input logic br,
                         input logic mr, input logic [4:0] rd,
                         input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2);
        dmem_busywait      = dm;
        imem_busywait      = im;
        branch_jump_signal = br;
        ex_mem_read        = mr;
        ex_rd              = rd;
        id_rs1             = r1;
        id_rs1_used        = u1;
        id_rs2             = r2;
        id_rs2_used        = u2;
    endtask

    task automatic expect_out(input string nm, input logic [6:0] c, input logic [1:0] s,
                              input int unsigned sc, input int unsigned fc);
        exp_t e;
        e.name = nm;
        e.ctrl = c;
        e.st   = s;
        e.sc   = sc;
        e.fc   = fc;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Control vector shorthands
    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_RST   = 7'b100_0011;
    localparam logic [6:0] C_LU    = 7'b110_0001;
    localparam logic [6:0] C_MEM   = 7'b111_1100;
    localparam logic [6:0] C_BR    = 7'b000_0011;
    localparam logic [6:0] C_IMEM  = 7'b100_0010;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = exp_q.pop_front();
            act = {pc_stall, if_id_busywait, id_ex_busywait, ex_mem_busywait, mem_wb_busywait,
                   if_id_flush, id_ex_flush};
            n_checks++;
            if (act !== e.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.ctrl);
            end
            n_checks++;
            if (ctrl_state !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %b want %b", e.name, ctrl_state, e.st);
            end
            n_checks++;
            if (stall_count !== e.sc || flush_count !== e.fc) begin
                n_fail++;
                $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         e.name, stall_count, flush_count, e.sc, e.fc);
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b0;
        drive(1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        next_cycle(); expect_out("reset_hold", C_RST, 2'd0, 0, 0);

        next_cycle(); reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("idle", C_NONE, 2'd0, 0, 0);

        // Load-use on rs1, then masked in LOAD_USE
        next_cycle(); drive(0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0);
        expect_out("lu_c1", C_LU, 2'd0, 0, 0);
        next_cycle(); expect_out("lu_c2_masked", C_NONE, 2'd1, 1, 0);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("lu_c3", C_NONE, 2'd0, 1, 0);

        // x0 destination never creates a hazard
        next_cycle(); drive(0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1);
        expect_out("rd_zero", C_NONE, 2'd0, 1, 0);

        // dmem wait for 3 cycles hides a pending branch
        next_cycle(); drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("mem_c1", C_MEM, 2'd0, 1, 0);
        next_cycle(); expect_out("mem_c2", C_MEM, 2'd2, 2, 0);
        next_cycle(); expect_out("mem_c3", C_MEM, 2'd2, 3, 0);
        next_cycle(); drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("mem_exit_br", C_BR, 2'd2, 4, 0);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("redirect_one", C_NONE, 2'd3, 4, 1);
        next_cycle(); expect_out("back_run", C_NONE, 2'd0, 4, 1);

        // Branch beats load-use; load-use then masked in REDIRECT
        next_cycle(); drive(0, 0, 1, 1, 5'd6, 5'd6, 1, 5'd0, 0);
        expect_out("br_over_lu", C_BR, 2'd0, 4, 1);
        next_cycle(); drive(0, 0, 0, 1, 5'd6, 5'd6, 1, 5'd0, 0);
        expect_out("lu_masked_redir", C_NONE, 2'd3, 4, 2);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("run_after_redir", C_NONE, 2'd0, 4, 2);

        // Back-to-back branches keep flushing in REDIRECT
        next_cycle(); drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        expect_out("br1", C_BR, 2'd0, 4, 2);
        next_cycle(); expect_out("br2_in_redir", C_BR, 2'd3, 4, 3);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("br2_after", C_NONE, 2'd3, 4, 4);
        next_cycle(); expect_out("br2_run", C_NONE, 2'd0, 4, 4);

        // imem wait for 2 cycles
        next_cycle(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        expect_out("imem_c1", C_IMEM, 2'd0, 4, 4);
        next_cycle(); expect_out("imem_c2", C_IMEM, 2'd0, 5, 4);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("imem_done", C_NONE, 2'd0, 6, 4);

        // Load-use beats imem wait
        next_cycle(); drive(0, 1, 0, 1, 5'd3, 5'd3, 1, 5'd0, 0);
        expect_out("lu_over_imem", C_LU, 2'd0, 6, 4);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("lu_over_imem_2", C_NONE, 2'd1, 7, 4);

        // rs2 match, and unused-source match
        next_cycle(); drive(0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1);
        expect_out("lu_rs2", C_LU, 2'd0, 7, 4);
        next_cycle(); drive(0, 0, 0, 1, 5'd9, 5'd9, 0, 5'd9, 0);
        expect_out("unused_src", C_NONE, 2'd1, 8, 4);

        // Async reset during MEM_WAIT
        next_cycle(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("mw_pre1", C_MEM, 2'd0, 8, 4);
        next_cycle(); expect_out("mw_pre2", C_MEM, 2'd2, 9, 4);
        next_cycle(); reset = 1'b0;
        expect_out("async_rst", C_RST, 2'd0, 0, 0);
        next_cycle(); expect_out("rst_held", C_RST, 2'd0, 0, 0);
        next_cycle(); reset = 1'b1; drive(0, 0, 0, 1, 5'd4, 5'd4, 1, 5'd0, 0);
        expect_out("post_rst_lu", C_LU, 2'd0, 0, 0);
        next_cycle(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("post_rst_lu2", C_NONE, 2'd1, 1, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port imem_busywait  in  1  instruction memory not ready.
REQ-005 SHALL have port dmem_busywait  in  1  data memory not ready.
REQ-006 SHALL have port branch_jump_signal  in  1  EX-stage redirect taken.
REQ-007 SHALL have ports id_rs1, id_rs2  in  REG_ADDR_W  ID-stage source registers.
REQ-008 SHALL have ports id_rs1_used, id_rs2_used  in  1  ID-stage source is read.
REQ-009 SHALL have ports ex_rd  in  REG_ADDR_W and ex_mem_read  in  1  EX-stage destination and load flag.
REQ-010 SHALL have port pc_stall  out  1  hold PC.
REQ-011 SHALL have ports if_id_busywait, id_ex_busywait, ex_mem_busywait, mem_wb_busywait  out  1  hold the named pipeline register.
REQ-012 SHALL have ports if_id_flush, id_ex_flush  out  1  load zeros (bubble) into the named register.
REQ-013 SHALL have port ctrl_state  out  2  current FSM state.
REQ-014 SHALL have ports stall_count, flush_count  out  32  performance counters.

Function
REQ-015 SHALL implement FSM states RUN=00, LOAD_USE=01, MEM_WAIT=10, REDIRECT=11; ctrl_state SHALL equal the state register.
REQ-016 SHALL compute load_use = ex_mem_read & (ex_rd != 0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)), masked to 0 in states LOAD_USE and REDIRECT.
REQ-017 SHALL resolve events combinationally in priority: dmem_busywait > branch_jump_signal > load_use > imem_busywait > none.
REQ-018 dmem_busywait=1: pc_stall and all four busywait outputs 1, both flushes 0, next state MEM_WAIT; branch_jump_signal ignored (EX is held, so it is re-presented).
REQ-019 MEM_WAIT SHALL persist while dmem_busywait=1 and exit by the same priority rules on the first cycle it is 0.
REQ-020 branch_jump_signal=1 (no dmem wait): if_id_flush=1, id_ex_flush=1, pc_stall=0, all busywaits 0, next state REDIRECT.
REQ-021 REDIRECT SHALL last exactly one cycle, then apply normal priority; a second branch in REDIRECT SHALL flush again and remain in REDIRECT.
REQ-022 load_use=1: pc_stall=1, if_id_busywait=1, id_ex_flush=1, other outputs 0, next state LOAD_USE; LOAD_USE lasts one cycle.
REQ-023 imem_busywait=1 alone: pc_stall=1, if_id_flush=1, downstream busywaits 0, state RUN.
REQ-024 No event: all control outputs 0, next state RUN.
REQ-025 stall_count SHALL increment by 1 on each edge where pc_stall=1 due to dmem, load_use or imem, saturating at 0xFFFFFFFF.
REQ-026 flush_count SHALL increment by 1 on each edge where a branch flush occurs, saturating at 0xFFFFFFFF.
REQ-027 Control outputs SHALL be combinational from state and inputs (zero-cycle latency); only state and counters are registered.

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) set state RUN, stall_count=0, flush_count=0.
REQ-029 While reset=0: pc_stall=1, if_id_flush=1, id_ex_flush=1, all busywaits 0, regardless of other inputs.
REQ-030 Reset asserted mid-MEM_WAIT, LOAD_USE or REDIRECT SHALL abandon that state; first edge after release evaluates from RUN.

Verification
REQ-031 ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> cycle 1 pc_stall=1, if_id_busywait=1, id_ex_flush=1, state 01; cycle 2 outputs 0, state 00; stall_count=1.
REQ-032 ex_rd=0 with matching id_rs1=0 and ex_mem_read=1 -> no stall, state RUN.
REQ-033 dmem_busywait=1 for 3 cycles with branch_jump_signal=1 -> all busywaits 1 for 3 cycles, no flush; cycle 4 flush, state 11; stall_count=3, flush_count=1.
REQ-034 branch_jump_signal=1 and load_use=1 together -> flushes only, pc_stall=0, state 11; next cycle load_use masked.
REQ-035 imem_busywait=1 for 2 cycles -> pc_stall=1, if_id_flush=1, id_ex_busywait=0; stall_count=2.
REQ-036 reset=0 asynchronously during MEM_WAIT with counters nonzero -> state 00, counters 0 before next clk edge.
